// File: rtl/demux2_20_buf.sv
// Pair writer for a 10-entry sample bank: fills slots 0..4 with (in1,in2) pairs,
// then holds the complete frame until the consumer acknowledges it.
module demux2_20_buf #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [2:0]       wr_sel,
    output logic             frame_valid,
    input  logic             frame_ack,
    output logic [WIDTH-1:0] out_0,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2,
    output logic [WIDTH-1:0] out_3,
    output logic [WIDTH-1:0] out_4,
    output logic [WIDTH-1:0] out_5,
    output logic [WIDTH-1:0] out_6,
    output logic [WIDTH-1:0] out_7,
    output logic [WIDTH-1:0] out_8,
    output logic [WIDTH-1:0] out_9
);

    typedef enum logic [0:0] {StFill, StHold} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic             fv_q, fv_d;
    logic [2:0]       slot;
    logic             accept;
    logic [WIDTH-1:0] bank_q [10];

    assign in_ready = (state_q == StFill);
    assign accept   = in_valid && in_ready && !flush;
    // Out-of-range selector values are treated as slot 0.
    assign slot     = (sel_q > 3'd4) ? 3'd0 : sel_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        fv_d    = fv_q;
        if (flush) begin
            state_d = StFill;
            sel_d   = 3'd0;
            fv_d    = 1'b0;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (accept) begin
                        if (slot == 3'd4) begin
                            sel_d   = 3'd0;
                            state_d = StHold;
                            fv_d    = 1'b1;
                        end else begin
                            sel_d = slot + 3'd1;
                        end
                    end
                end
                StHold: begin
                    if (frame_ack) begin
                        state_d = StFill;
                        fv_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = StFill;
                    sel_d   = 3'd0;
                    fv_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFill;
            sel_q   <= 3'd0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            fv_q    <= fv_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 10; k++) begin
                bank_q[k] <= '0;
            end
        end else if (accept) begin
            bank_q[{slot, 1'b0}] <= in1;
            bank_q[{slot, 1'b1}] <= in2;
        end
    end

    assign wr_sel      = sel_q;
    assign frame_valid = fv_q;
    assign out_0       = bank_q[0];
    assign out_1       = bank_q[1];
    assign out_2       = bank_q[2];
    assign out_3       = bank_q[3];
    assign out_4       = bank_q[4];
    assign out_5       = bank_q[5];
    assign out_6       = bank_q[6];
    assign out_7       = bank_q[7];
    assign out_8       = bank_q[8];
    assign out_9       = bank_q[9];

endmodule

// File: tb/tb_demux2_20_buf.sv
// Randomized bench for demux2_20_buf against a frame-level reference model.
module tb_demux2_20_buf;

    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, frame_ack;
    logic         in_ready, frame_valid;
    logic [W-1:0] in1, in2;
    logic [2:0]   wr_sel;
    logic [W-1:0] o0, o1, o2, o3, o4, o5, o6, o7, o8, o9;

    int checks = 0;
    int passed = 0;

    // Reference model: the frame as an array, the next slot and a held flag.
    logic [W-1:0] m_bank [10];
    int           m_sel;
    bit           m_hold;

    demux2_20_buf #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .wr_sel(wr_sel), .frame_valid(frame_valid),
        .frame_ack(frame_ack),
        .out_0(o0), .out_1(o1), .out_2(o2), .out_3(o3), .out_4(o4),
        .out_5(o5), .out_6(o6), .out_7(o7), .out_8(o8), .out_9(o9)
    );

    always #5 clk = ~clk;

    function automatic logic [10*W-1:0] dut_bank();
        return {o9, o8, o7, o6, o5, o4, o3, o2, o1, o0};
    endfunction

    function automatic logic [10*W-1:0] model_bank();
        logic [10*W-1:0] v;
        for (int k = 0; k < 10; k++) v[k*W +: W] = m_bank[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 10; k++) m_bank[k] = '0;
        m_sel  = 0;
        m_hold = 0;
    endtask

    task automatic model_edge(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                              input bit ack, input bit fl);
        if (fl) begin
            m_sel  = 0;
            m_hold = 0;
        end else if (m_hold) begin
            if (ack) m_hold = 0;
        end else if (v) begin
            m_bank[2*m_sel]   = a;
            m_bank[2*m_sel+1] = b;
            m_sel = m_sel + 1;
            if (m_sel == 5) begin
                m_sel  = 0;
                m_hold = 1;
            end
        end
    endtask

    // Drive one cycle from a negedge, advance the model at the edge, return at next negedge.
    task automatic cycle(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit ack, input bit fl);
        in_valid = v; in1 = a; in2 = b; frame_ack = ack; flush = fl;
        @(posedge clk);
        model_edge(v, a, b, ack, fl);
        @(negedge clk);
        in_valid = 0; frame_ack = 0; flush = 0;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; in_valid = 0; frame_ack = 0; in1 = '0; in2 = '0;
        model_reset();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        else passed++;
        checks++;
        if (wr_sel !== 3'd0 || frame_valid !== 1'b0)
            $display("FAIL reset_ctrl got sel=%0d fv=%b exp sel=0 fv=0", wr_sel, frame_valid);
        else passed++;
        checks++;
        if (dut_bank() !== model_bank()) $display("FAIL reset_bank got=%h exp=%h", dut_bank(), model_bank());
        else passed++;
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (wr_sel !== 3'(m_sel) || in_ready !== 1'b1)
                $display("FAIL b2b_sel got sel=%0d rdy=%b exp sel=%0d rdy=1", wr_sel, in_ready, m_sel);
            else passed++;
            cycle(1, W'(2*i+1), W'(2*i+2), 0, 0);
        end
        checks++;
        if (frame_valid !== 1'b1 || in_ready !== 1'b0 || wr_sel !== 3'd0)
            $display("FAIL b2b_done got fv=%b rdy=%b sel=%0d exp 1 0 0", frame_valid, in_ready, wr_sel);
        else passed++;
        checks++;
        if (dut_bank() !== model_bank()) $display("FAIL b2b_bank got=%h exp=%h", dut_bank(), model_bank());
        else passed++;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) cycle(1, 5'd31, 5'd31, 0, 0);
        checks++;
        if (dut_bank() !== model_bank() || frame_valid !== 1'b1 || wr_sel !== 3'd0)
            $display("FAIL hold_stable got=%h fv=%b sel=%0d exp=%h fv=1 sel=0",
                     dut_bank(), frame_valid, wr_sel, model_bank());
        else passed++;
        cycle(1, 5'd31, 5'd31, 1, 0);
        checks++;
        if (frame_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL hold_ack got fv=%b rdy=%b exp fv=0 rdy=1", frame_valid, in_ready);
        else passed++;
        checks++;
        if (dut_bank() !== model_bank() || wr_sel !== 3'd0)
            $display("FAIL ack_no_write got=%h sel=%0d exp=%h sel=0", dut_bank(), wr_sel, model_bank());
        else passed++;
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 5; i++) begin
            cycle(1, W'($urandom_range(0, 31)), W'($urandom_range(0, 31)), 0, 0);
            for (int g = 0; g < 2 && i < 4; g++) cycle(0, W'($urandom), W'($urandom), 0, 0);
            checks++;
            if (wr_sel !== 3'(m_sel) || frame_valid !== 1'(m_hold))
                $display("FAIL gap_sel got sel=%0d fv=%b exp sel=%0d fv=%b",
                         wr_sel, frame_valid, m_sel, m_hold);
            else passed++;
        end
        checks++;
        if (dut_bank() !== model_bank()) $display("FAIL gap_bank got=%h exp=%h", dut_bank(), model_bank());
        else passed++;
        cycle(0, '0, '0, 1, 0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cycle(1, W'($urandom), W'($urandom), 0, 0);
        cycle(1, 5'd17, 5'd19, 0, 1);
        checks++;
        if (wr_sel !== 3'd0 || in_ready !== 1'b1 || frame_valid !== 1'b0)
            $display("FAIL flush_ctrl got sel=%0d rdy=%b fv=%b exp 0 1 0", wr_sel, in_ready, frame_valid);
        else passed++;
        checks++;
        if (dut_bank() !== model_bank()) $display("FAIL flush_bank got=%h exp=%h", dut_bank(), model_bank());
        else passed++;
        for (int i = 0; i < 5; i++) cycle(1, W'($urandom), W'($urandom), 0, 0);
        checks++;
        if (dut_bank() !== model_bank() || frame_valid !== 1'b1)
            $display("FAIL flush_refill got=%h fv=%b exp=%h fv=1", dut_bank(), frame_valid, model_bank());
        else passed++;
        // Flush while holding drops the frame without an ack.
        cycle(0, '0, '0, 0, 1);
        checks++;
        if (frame_valid !== 1'b0 || in_ready !== 1'b1 || dut_bank() !== model_bank())
            $display("FAIL flush_hold got fv=%b rdy=%b exp fv=0 rdy=1", frame_valid, in_ready);
        else passed++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 29) == 0));
            checks++;
            if (dut_bank() !== model_bank() || wr_sel !== 3'(m_sel) ||
                frame_valid !== 1'(m_hold) || in_ready !== !m_hold) begin
                if (errs < 5)
                    $display("FAIL rand_cycle%0d got bank=%h sel=%0d fv=%b exp bank=%h sel=%0d fv=%b",
                             i, dut_bank(), wr_sel, frame_valid, model_bank(), m_sel, m_hold);
                errs++;
            end else passed++;
        end
        if (m_hold) cycle(0, '0, '0, 1, 0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cycle(1, W'($urandom_range(1, 31)), W'($urandom_range(1, 31)), 0, 0);
        cycle(0, '0, '0, 0, 0);
        #2 rst = 1;
        model_reset();
        #1;
        checks++;
        if (frame_valid !== 1'b0 || wr_sel !== 3'd0 || in_ready !== 1'b1)
            $display("FAIL async_rst_ctrl got fv=%b sel=%0d rdy=%b exp 0 0 1", frame_valid, wr_sel, in_ready);
        else passed++;
        checks++;
        if (dut_bank() !== model_bank()) $display("FAIL async_rst_bank got=%h exp=0", dut_bank());
        else passed++;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 2; i++) cycle(0, '0, '0, 1, 0);
        checks++;
        if (frame_valid !== 1'b0 || wr_sel !== 3'd0 || in_ready !== 1'b1)
            $display("FAIL ack_in_fill got fv=%b sel=%0d rdy=%b exp 0 0 1", frame_valid, wr_sel, in_ready);
        else passed++;
        cycle(1, 5'd7, 5'd9, 1, 0);
        checks++;
        if (wr_sel !== 3'd1 || dut_bank() !== model_bank())
            $display("FAIL accept_with_ack got sel=%0d bank=%h exp sel=1 bank=%h",
                     wr_sel, dut_bank(), model_bank());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_hold();
        test_gapped();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/demux2_20_buf.md
Name: demux2_20_buf

Overview:
- Write-side counterpart of the IQ demodulator's 10-input / 2-output pair selector.
- Accepts one pair of WIDTH-bit samples per handshake and writes the pair into a 10-entry register bank, filling slots 0..4 in order.
- Slot k holds entries 2k and 2k+1.
- Once all five pairs are stored, it presents the bank as a complete frame, holds it until the consumer acknowledges, then refills.

Parameters:
WIDTH, 5, bit width of each sample and of each stored entry

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous abort: discard partial/held frame, restart at slot 0
in_valid  input  1  in1/in2 carry a valid sample pair
in_ready  output  1  block can accept a pair this cycle
in1  input  WIDTH  first sample of pair, goes to entry 2*slot
in2  input  WIDTH  second sample of pair, goes to entry 2*slot+1
wr_sel  output  3  slot the next accepted pair will be written to, 0..4; same encoding as the reader's sel
frame_valid  output  1  all 10 entries hold a complete frame
frame_ack  input  1  consumer has taken the frame; single-cycle pulse
out_0 .. out_9  output  WIDTH each  registered bank entries, ten separate ports

Behaviour:
- Reset (async, rst=1):
  - state=FILL, wr_sel=0, frame_valid=0, all out_0..out_9=0.
  - in_ready=1 once state=FILL, including while rst is held.
- States: FILL, HOLD. in_ready = (state==FILL), decoded combinationally from the state register. frame_valid = (state==HOLD), registered.
- Write handshake in FILL: a pair is accepted on a rising edge where in_valid=1 and in_ready=1.
  - out_{2*wr_sel} <= in1; out_{2*wr_sel+1} <= in2.
  - All other entries keep their value.
- Slot counter:
  - On accept with wr_sel<4: wr_sel <= wr_sel+1, stay in FILL.
  - On accept with wr_sel==4: wr_sel <= 0, state <= HOLD. frame_valid rises the cycle after the 5th accept (latency 1 edge).
- HOLD:
  - in_ready=0; in_valid is ignored and no entry changes.
  - out_* stay stable for the whole HOLD period.
  - On frame_ack=1: state <= FILL, frame_valid <= 0 on that edge, so in_ready=1 the following cycle.
  - A pair presented in the ack cycle is NOT accepted.
- frame_ack while in FILL is ignored.
- flush=1 has priority over everything, in any state:
  - Next edge: state=FILL, wr_sel=0, frame_valid=0.
  - out_* keep their stale contents; they are not cleared.
  - A concurrent in_valid is not accepted.
- wr_sel never takes values 5..7. If 5..7 is detected, treat it as 0 on the next accept (defensive wrap).
- Back-to-back: in_valid held high with continuous data fills a frame in 5 consecutive cycles.
  - Minimum frame period is 5 fill cycles + 1 HOLD cycle when ack arrives in the first HOLD cycle.
- Reset mid-frame: asynchronously returns everything to reset values regardless of state; the partial frame is lost.
- No combinational path from any input to any output except in_ready, which derives from state only.

Test Plan:
- Reset → in_ready=1, wr_sel=0, frame_valid=0, out_0..out_9=0.
- Five back-to-back accepts with pairs (1,2),(3,4),(5,6),(7,8),(9,10) → wr_sel steps 0,1,2,3,4,0; frame_valid=1 one edge after the 5th accept; out_0..out_9 = 1..10; in_ready=0.
- In HOLD, drive in_valid=1 with (31,31) for 3 cycles, no ack → outputs unchanged at 1..10, wr_sel=0; then pulse frame_ack → frame_valid=0 and in_ready=1 next cycle; the pair presented during the ack cycle is not written.
- Gapped input: pairs with in_valid low for 2 cycles between each accept → same final bank as the back-to-back case; wr_sel advances only on accepted cycles.
- Three accepts (wr_sel=3), then flush=1 together with in_valid=1 → wr_sel=0, state FILL, out_6/out_7 not written; next 5 accepts produce a fresh frame.
- Assert rst asynchronously mid-HOLD, between clock edges → frame_valid, wr_sel and all out_* go to 0 immediately, without waiting for a clock edge; frame_ack pulses in FILL have no effect.
